// File: rtl/fifo_flow_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flow_controller_pkg
// Description : Shared constants for the capture -> FIFO -> UART byte path.
//               Holds the UART clock constants, the flow-controller default
//               thresholds and the controller state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_flow_controller_pkg;

    // UART clocking for the byte path
    localparam int c_SYS_CLK_HZ    = 50_000_000;
    localparam int c_UART_BAUD     = 9600;
    localparam int c_UART_CLK_DIV  = c_SYS_CLK_HZ / c_UART_BAUD;

    // Flow-controller defaults
    localparam int c_CNT_W_DEF      = 10;
    localparam int c_HIGH_WATER_DEF = 512;
    localparam int c_MAX_BURST_DEF  = 16;
    localparam int c_TIMEOUT_DEF    = 4095;

    // Controller state encodings (also exported on the debug state port)
    localparam int         c_STATE_W    = 3;
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_CAPTURE = 3'd1;
    localparam logic [2:0] c_ST_DRAIN   = 3'd2;
    localparam logic [2:0] c_ST_YIELD   = 3'd3;

endpackage : fifo_flow_controller_pkg
`default_nettype wire

// File: rtl/fifo_flow_controller_burst_timer.sv
`default_nettype none
// ============================================================================
// Module      : flow_burst_timer
// Description : Loadable down-counter shared between the drain burst counter
//               and the capture timeout timer. Load has priority over
//               decrement; the counter holds at zero.
// Ports       : clk        - stage clock
//               reset      - synchronous, active-low reset
//               i_load     - load i_load_val on the next edge
//               i_load_val - value to load
//               i_dec      - decrement by one (ignored at zero)
//               o_zero     - counter is zero
// Revision    : 1.0 - initial release
// ============================================================================
module flow_burst_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count;

    always_comb begin
        w_count = r_count;
        if (i_load) begin
            w_count = i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            w_count = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : flow_burst_timer
`default_nettype wire

// File: rtl/fifo_flow_controller.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flow_controller
// Description : Grants the single FIFO either to the capture stage (writer)
//               or to the drain/transmit stages (reader). Drain starts on a
//               flush request or at the high-water mark and is burst-limited
//               so a waiting capture is never starved. All outputs are
//               registered.
// Ports       : clk, reset        - stage clock, sync active-low reset
//               in_req, in_done   - capture byte ready / write finished
//               drain_req         - flush request pulse
//               fifo_*            - FIFO occupancy and status
//               out_finish        - UART finished one byte
//               capture_en, drain_en, tx_en - stage enables
//               state             - current state (debug)
//               overflow, timeout - sticky error flags
//               drain_pending     - flush request not yet served
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flow_controller
    import fifo_flow_controller_pkg::*;
#(
    parameter int CNT_W      = c_CNT_W_DEF,
    parameter int HIGH_WATER = c_HIGH_WATER_DEF,
    parameter int MAX_BURST  = c_MAX_BURST_DEF,
    parameter int TIMEOUT    = c_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_req,
    input  logic                 in_done,
    input  logic                 drain_req,
    input  logic [CNT_W-1:0]     fifo_count,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    input  logic                 fifo_busy,
    input  logic                 out_finish,
    output logic                 capture_en,
    output logic                 drain_en,
    output logic                 tx_en,
    output logic [c_STATE_W-1:0] state,
    output logic                 overflow,
    output logic                 timeout,
    output logic                 drain_pending
);

    // Timer is sized for the timeout; the burst limit is assumed smaller.
    localparam int               c_TMR_W      = $clog2(TIMEOUT + 1);
    // Loading N-1 and exiting on zero gives exactly N cycles / N bytes.
    localparam logic [c_TMR_W-1:0] c_TMO_LOAD   = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_BURST_LOAD = c_TMR_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0]   c_HIGH_WATER = CNT_W'(HIGH_WATER);

    logic [c_STATE_W-1:0] r_state;
    logic                 r_capture_en;
    logic                 r_drain_en;
    logic                 r_tx_en;
    logic                 r_overflow;
    logic                 r_timeout;
    logic                 r_drain_pending;

    logic [c_STATE_W-1:0] w_state;
    logic                 w_overflow;
    logic                 w_timeout;
    logic                 w_drain_pending;
    logic                 w_pend_set;
    logic                 w_pend_clr;
    logic                 w_tmr_load;
    logic [c_TMR_W-1:0]   w_tmr_load_val;
    logic                 w_tmr_dec;
    logic                 w_tmr_zero;

    flow_burst_timer #(
        .WIDTH(c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state        = r_state;
        w_overflow     = r_overflow;
        w_timeout      = r_timeout;
        w_pend_set     = drain_req || (fifo_count >= c_HIGH_WATER);
        w_pend_clr     = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = '0;
        w_tmr_dec      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (!fifo_busy) begin
                    // Overflow is recorded even when drain takes the grant.
                    if (in_req && fifo_full) begin
                        w_overflow = 1'b1;
                    end
                    if (in_req && !fifo_full) begin
                        w_state        = c_ST_CAPTURE;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = c_TMO_LOAD;
                    end else if (r_drain_pending && !fifo_empty) begin
                        w_state        = c_ST_DRAIN;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = c_BURST_LOAD;
                    end else if (r_drain_pending && fifo_empty) begin
                        w_pend_clr = 1'b1;
                    end
                end
            end

            c_ST_CAPTURE: begin
                if (in_done) begin
                    w_state = c_ST_IDLE;
                end else if (w_tmr_zero) begin
                    w_timeout = 1'b1;
                    w_state   = c_ST_IDLE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end

            c_ST_DRAIN: begin
                // Only leave on a byte boundary so no byte is cut short.
                if (out_finish) begin
                    if (fifo_empty) begin
                        w_pend_clr = 1'b1;
                        w_state    = c_ST_IDLE;
                    end else if (w_tmr_zero) begin
                        if (in_req) begin
                            w_state = c_ST_YIELD;
                        end else begin
                            w_tmr_load     = 1'b1;
                            w_tmr_load_val = c_BURST_LOAD;
                        end
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
            end

            c_ST_YIELD: begin
                w_state = c_ST_IDLE;
            end

            default: begin
                w_state = c_ST_IDLE;
            end
        endcase

        // A new request in the same cycle as service keeps the flag set.
        if (w_pend_set) begin
            w_drain_pending = 1'b1;
        end else if (w_pend_clr) begin
            w_drain_pending = 1'b0;
        end else begin
            w_drain_pending = r_drain_pending;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= c_ST_IDLE;
            r_capture_en    <= 1'b0;
            r_drain_en      <= 1'b0;
            r_tx_en         <= 1'b0;
            r_overflow      <= 1'b0;
            r_timeout       <= 1'b0;
            r_drain_pending <= 1'b0;
        end else begin
            r_state         <= w_state;
            // Enables follow the next state, so they are exclusive by design.
            r_capture_en    <= (w_state == c_ST_CAPTURE);
            r_drain_en      <= (w_state == c_ST_DRAIN);
            r_tx_en         <= (w_state == c_ST_DRAIN);
            r_overflow      <= w_overflow;
            r_timeout       <= w_timeout;
            r_drain_pending <= w_drain_pending;
        end
    end

    assign state         = r_state;
    assign capture_en    = r_capture_en;
    assign drain_en      = r_drain_en;
    assign tx_en         = r_tx_en;
    assign overflow      = r_overflow;
    assign timeout       = r_timeout;
    assign drain_pending = r_drain_pending;

endmodule : fifo_flow_controller
`default_nettype wire

// File: tb/tb_fifo_flow_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_flow_controller
// Description : Directed self-checking bench for fifo_flow_controller.
//               Expected values are queued as stimulus is applied and popped
//               when the corresponding DUT output is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flow_controller;

    localparam int c_CNT_W   = 10;
    localparam int c_TIMEOUT = 4095;

    logic             clk;
    logic             reset;
    logic             in_req;
    logic             in_done;
    logic             drain_req;
    logic [c_CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_busy;
    logic             out_finish;
    logic             capture_en;
    logic             drain_en;
    logic             tx_en;
    logic [2:0]       state;
    logic             overflow;
    logic             timeout;
    logic             drain_pending;

    fifo_flow_controller #(
        .CNT_W      (c_CNT_W),
        .HIGH_WATER (512),
        .MAX_BURST  (16),
        .TIMEOUT    (c_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_req        (in_req),
        .in_done       (in_done),
        .drain_req     (drain_req),
        .fifo_count    (fifo_count),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_busy     (fifo_busy),
        .out_finish    (out_finish),
        .capture_en    (capture_en),
        .drain_en      (drain_en),
        .tx_en         (tx_en),
        .state         (state),
        .overflow      (overflow),
        .timeout       (timeout),
        .drain_pending (drain_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic excl_viol = 1'b0;

    // Capture must never be enabled alongside drain or transmit.
    always @(negedge clk) begin
        if (reset && capture_en && (drain_en || tx_en)) excl_viol = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] ov(input int st, input bit c, input bit d,
                                       input bit t, input bit o, input bit to,
                                       input bit p);
        logic [2:0] s3;
        s3 = st[2:0];
        return {23'd0, s3, c, d, t, o, to, p};
    endfunction

    function automatic logic [31:0] outs();
        return {23'd0, state, capture_en, drain_en, tx_en, overflow, timeout, drain_pending};
    endfunction

    task automatic pexp(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sbq.size() == 0) begin
            $display("FAIL sb_empty observed=0x%0h required=none", obs);
            return;
        end
        e = sbq.pop_front();
        assert (obs === e.exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
    endtask

    // Idle gap cycle, then a one-cycle out_finish; observation follows the pulse edge.
    task automatic pulse_finish();
        tick();
        out_finish = 1'b1;
        tick();
        out_finish = 1'b0;
    endtask

    initial begin
        int cap_cnt;
        int n;
        bit grant;

        reset      = 1'b0;
        in_req     = 1'b1;
        in_done    = 1'b0;
        drain_req  = 1'b0;
        fifo_count = '0;
        fifo_empty = 1'b1;
        fifo_full  = 1'b0;
        fifo_busy  = 1'b0;
        out_finish = 1'b0;

        // Reset held with in_req high
        repeat (3) tick();
        pexp("reset_outs", ov(0, 0, 0, 0, 0, 0, 0));
        cmp(outs());

        reset = 1'b1;
        tick();
        pexp("release_grant", ov(1, 1, 0, 0, 0, 0, 0));
        cmp(outs());
        in_done = 1'b1;
        in_req  = 1'b0;
        tick();
        in_done = 1'b0;
        pexp("release_done", ov(0, 0, 0, 0, 0, 0, 0));
        cmp(outs());

        // Normal capture with in_done after four capture cycles
        tick();
        in_req  = 1'b1;
        cap_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cap_cnt += int'(capture_en);
        end
        in_done = 1'b1;
        in_req  = 1'b0;
        tick();
        in_done = 1'b0;
        pexp("cap_len", 32'd4);
        pexp("cap_end", ov(0, 0, 0, 0, 0, 0, 0));
        cmp(cap_cnt);
        cmp(outs());

        // User flush of three bytes
        fifo_count = 10'd3;
        fifo_empty = 1'b0;
        drain_req  = 1'b1;
        tick();
        drain_req = 1'b0;
        pexp("flush_pending", ov(0, 0, 0, 0, 0, 0, 1));
        cmp(outs());
        tick();
        pexp("flush_drain", ov(2, 0, 1, 1, 0, 0, 1));
        cmp(outs());
        fifo_count = 10'd2;
        pulse_finish();
        fifo_count = 10'd1;
        pulse_finish();
        pexp("flush_mid", ov(2, 0, 1, 1, 0, 0, 1));
        cmp(outs());
        fifo_count = 10'd0;
        fifo_empty = 1'b1;
        pulse_finish();
        pexp("flush_done", ov(0, 0, 0, 0, 0, 0, 0));
        cmp(outs());

        // Auto-drain at high water, burst wrap, then yield to a capture
        fifo_count = 10'd520;
        fifo_empty = 1'b0;
        tick();
        pexp("hw_pending", ov(0, 0, 0, 0, 0, 0, 1));
        cmp(outs());
        tick();
        pexp("hw_drain", ov(2, 0, 1, 1, 0, 0, 1));
        cmp(outs());
        repeat (16) pulse_finish();
        pexp("burst_wrap", ov(2, 0, 1, 1, 0, 0, 1));
        cmp(outs());
        in_req = 1'b1;
        repeat (15) pulse_finish();
        pexp("burst_15", ov(2, 0, 1, 1, 0, 0, 1));
        cmp(outs());
        pulse_finish();
        pexp("yield", ov(3, 0, 0, 0, 0, 0, 1));
        cmp(outs());
        tick();
        pexp("yield_idle", ov(0, 0, 0, 0, 0, 0, 1));
        cmp(outs());
        tick();
        pexp("yield_capture", ov(1, 1, 0, 0, 0, 0, 1));
        cmp(outs());
        in_done = 1'b1;
        in_req  = 1'b0;
        tick();
        in_done = 1'b0;
        tick();
        pexp("drain_resume", ov(2, 0, 1, 1, 0, 0, 1));
        cmp(outs());
        fifo_count = 10'd0;
        fifo_empty = 1'b1;
        pulse_finish();
        pexp("hw_done", ov(0, 0, 0, 0, 0, 0, 0));
        cmp(outs());

        // Overflow: full FIFO with capture waiting and a flush requested
        fifo_count = 10'd10;
        fifo_empty = 1'b0;
        fifo_full  = 1'b1;
        in_req     = 1'b1;
        drain_req  = 1'b1;
        tick();
        drain_req = 1'b0;
        pexp("ovf_set", ov(0, 0, 0, 0, 1, 0, 1));
        cmp(outs());
        tick();
        pexp("ovf_drain", ov(2, 0, 1, 1, 1, 0, 1));
        cmp(outs());
        in_req     = 1'b0;
        fifo_full  = 1'b0;
        fifo_count = 10'd0;
        fifo_empty = 1'b1;
        pulse_finish();
        pexp("ovf_sticky", ov(0, 0, 0, 0, 1, 0, 0));
        cmp(outs());

        // Capture timeout
        in_req = 1'b1;
        tick();
        pexp("tmo_capture", ov(1, 1, 0, 0, 1, 0, 0));
        cmp(outs());
        n = 0;
        while (state == 3'd1 && n < 5000) begin
            tick();
            n++;
        end
        fifo_busy = 1'b1;
        pexp("tmo_cycles", c_TIMEOUT);
        pexp("tmo_flag", ov(0, 0, 0, 0, 1, 1, 0));
        cmp(n);
        cmp(outs());

        // Busy gating with in_req held
        grant = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (capture_en || state != 3'd0) grant = 1'b1;
        end
        pexp("busy_no_grant", 32'd0);
        cmp(32'(grant));
        fifo_busy = 1'b0;
        tick();
        pexp("busy_release", ov(1, 1, 0, 0, 1, 1, 0));
        cmp(outs());

        // Reset in the middle of a capture, no retry afterwards
        reset  = 1'b0;
        in_req = 1'b0;
        tick();
        pexp("mid_reset", ov(0, 0, 0, 0, 0, 0, 0));
        cmp(outs());
        reset = 1'b1;
        tick();
        pexp("no_retry", ov(0, 0, 0, 0, 0, 0, 0));
        cmp(outs());

        pexp("exclusive", 32'd0);
        cmp(32'(excl_viol));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fifo_flow_controller
`default_nettype wire

// File: doc/fifo_flow_controller.md
Name: fifo_flow_controller

Overview:
Sequences the byte path from switch capture into the FIFO, out of the FIFO and through the UART transmitter. It replaces the tie-high stage enables with registered grants. It arbitrates the single FIFO between the capture stage (writer) and the drain/transmit stages (reader). Drain starts on a user flush request or when the FIFO reaches a high-water mark, and drain is burst-limited so that a waiting capture is never starved.

Parameters:
CNT_W, 10, width of the FIFO occupancy count
HIGH_WATER, 512, occupancy at or above which drain auto-starts
MAX_BURST, 16, bytes sent per drain grant before yielding to a pending capture (power of two, ≥2)
TIMEOUT, 4095, clk cycles allowed for a capture to finish before abort

Ports:
clk  in  1  stage clock (UART-rate clock)
reset  in  1  synchronous, active-low reset
in_req  in  1  capture stage has a byte ready (tsent level)
in_done  in  1  capture stage finished its FIFO write (1-cycle pulse)
drain_req  in  1  user flush request (single-pulsed button)
fifo_count  in  CNT_W  FIFO occupancy
fifo_empty  in  1  FIFO empty
fifo_full  in  1  FIFO full
fifo_busy  in  1  FIFO internal operation in progress
out_finish  in  1  UART finished one byte (1-cycle pulse)
capture_en  out  1  enable for the capture→FIFO stage
drain_en  out  1  enable for the FIFO→out stage
tx_en  out  1  enable for the out→UART stage
state  out  3  current state encoding, for debug/seven-segment
overflow  out  1  sticky: in_req seen while FIFO full
timeout  out  1  sticky: capture aborted by timeout
drain_pending  out  1  latched flush request not yet served

Behaviour:
- All outputs registered. While reset=0 at a clk edge: state=IDLE; all enables, flags, burst counter and timer = 0.
- States: IDLE=0, CAPTURE=1, DRAIN=2, YIELD=3.
- drain_pending: set on drain_req, or on fifo_count ≥ HIGH_WATER evaluated in any state. Cleared only when DRAIN exits with FIFO empty. If set and clear occur in the same cycle, set wins.
- IDLE: all enables 0. No grant while fifo_busy=1. Otherwise, in priority order:
  (1) in_req && !fifo_full → CAPTURE.
  (2) drain_pending && !fifo_empty → DRAIN.
  (3) in_req && fifo_full → set overflow, stay IDLE.
  (4) drain_pending && fifo_empty → clear drain_pending, stay IDLE.
- CAPTURE: capture_en=1 starting the cycle after entry. The timer counts cycles from entry.
  - in_done → IDLE; the enable drops on the same edge.
  - Timer reaches TIMEOUT → set timeout, go to IDLE.
  - Reset mid-capture → IDLE immediately; the partial write is not retried.
- DRAIN: drain_en=tx_en=1. The burst counter starts at 0 and increments on each out_finish.
  - out_finish && fifo_empty → clear drain_pending, go to IDLE.
  - out_finish && count==MAX_BURST-1 && in_req → YIELD.
  - out_finish at MAX_BURST-1 without in_req → counter wraps to 0 and drain continues.
  - A byte in flight is never cut: exits occur only on out_finish.
- YIELD: one cycle with drain_en=tx_en=0, then go to IDLE. drain_pending stays set, so drain resumes after the capture.
- Simultaneous in_req and drain_pending in IDLE → capture wins, unless the FIFO is full; then drain wins.
- Enables are mutually exclusive: capture_en is never 1 in the same cycle as drain_en or tx_en.
- overflow and timeout clear only on reset.

Decomposition:
- Shared package/include: state encodings, default HIGH_WATER/MAX_BURST/TIMEOUT alongside the existing UART clock constants.
- One natural sub-module: flow_burst_timer, a shared down-counter used as the burst counter in DRAIN and the timeout timer in CAPTURE, with load/dec/zero outputs.

Test Plan:
- Reset: hold reset=0 for 3 clk with in_req=1 → all outputs 0, state=0. Release → capture_en=1 within 2 cycles.
- Capture: in_req=1, in_done pulse 5 cycles later → capture_en high for 4-5 cycles, then state=IDLE and capture_en=0.
- Flush: FIFO at count 3, pulse drain_req → drain_en=tx_en=1. After the 3rd out_finish (fifo_empty=1): state=IDLE, drain_pending=0.
- Auto-drain with yield: fifo_count=520, in_req asserted during drain → exactly 16 out_finish pulses, then YIELD for 1 cycle, then CAPTURE. After in_done, drain resumes with drain_pending=1.
- Overflow: fifo_full=1 and in_req=1 in IDLE, with drain_pending=1 → overflow=1 and state goes to DRAIN, never CAPTURE. overflow stays 1 after the FIFO empties.
- Timeout, then busy gating: capture with no in_done → timeout=1 and state=IDLE after 4095 cycles. Then fifo_busy=1 for 10 cycles with in_req=1 → no grant until fifo_busy falls.
